c2h_queue_arbiter: RTL and testbench
====================================

# c2h_queue_arbiter

Packet-granular, credit-gated round-robin scheduler that shares the single C2H AXI-Stream path between NUM_Q traffic-generator queues. It sits between the per-queue traffic generators and the C2H stream FIFO. It tracks descriptor credits per queue, grants one whole packet at a time, and tags each outgoing packet with its queue id.

## Interface
Parameters:
- NUM_Q, 4: number of requesting queues (2..16)
- QID_W, 2: queue-id width, equal to $clog2(NUM_Q)
- C_DATA_WIDTH, 512: stream data width
- TM_DSC_BITS, 16: credit counter width

Ports:
- axi_aclk, in, 1: clock
- axi_aresetn, in, 1: asynchronous active-low reset
- enable, in, 1: permits new grants
- credit_updt, in, 1: credit return strobe
- credit_qid, in, QID_W: queue receiving credit
- credit_in, in, TM_DSC_BITS: credits returned
- credit_perpkt, in, TM_DSC_BITS: credits consumed per packet
- s_tdata, in, NUM_Q*C_DATA_WIDTH: per-queue data, queue i at slice i
- s_tkeep, in, NUM_Q*C_DATA_WIDTH/8: per-queue byte enables
- s_tvalid, in, NUM_Q: per-queue valid
- s_tlast, in, NUM_Q: per-queue last
- s_tready, out, NUM_Q: per-queue ready
- m_tdata, out, C_DATA_WIDTH: data toward the C2H FIFO
- m_tkeep, out, C_DATA_WIDTH/8: byte enables toward the C2H FIFO
- m_tvalid, out, 1: valid toward the C2H FIFO
- m_tlast, out, 1: last toward the C2H FIFO
- m_tready, in, 1: ready from the C2H FIFO
- m_qid, out, QID_W: queue id of the current packet
- credit_avail, out, NUM_Q*TM_DSC_BITS: current credit per queue
- busy, out, 1: a packet is in flight
- pkt_cnt, out, NUM_Q*32: present only when C2H_ARB_PKT_CNT_EN is defined

## Operation
- FSM has two states, ARB and XFER. Reset state is ARB.
- Eligibility: queue i is eligible when s_tvalid[i] is high and credit[i] ≥ credit_perpkt.
- ARB:
  - If enable is high and any queue is eligible, select the first eligible queue searching upward from (last_grant+1) mod NUM_Q, with wrap-around.
  - Register the selection into grant and last_grant, subtract credit_perpkt from credit[grant], and move to XFER.
  - Otherwise stay in ARB.
- XFER: combinational pass-through of the granted queue.
  - m_tdata, m_tkeep and m_tlast come from queue grant's slice.
  - m_tvalid = s_tvalid[grant].
  - s_tready[grant] = m_tready; all other s_tready bits are 0.
  - m_qid = grant.
  - busy = 1.
- End of packet: when m_tvalid, m_tready and m_tlast are all high, the FSM returns to ARB.
- Outside XFER: m_tvalid=0, m_tlast=0, s_tready=0, busy=0. m_tdata, m_tkeep and m_qid hold don't-care values and are driven to 0.
- Credit update: on credit_updt, credit[credit_qid] += credit_in.
  - Saturate at 2^TM_DSC_BITS−1; no wrap.
  - Simultaneous update and grant on the same queue: new value = sat(credit + credit_in − credit_perpkt), computed at TM_DSC_BITS+1 bits.
- credit_perpkt = 0: any valid queue is eligible and credit is not decremented.
- enable deasserted mid-packet: the current packet completes and no new grant is made.
- A packet is never interrupted by another queue. Queues that are not granted see s_tready low.
- Reset, including mid-packet: FSM to ARB, grant=0, last_grant=NUM_Q−1 (so queue 0 wins first), all credits 0, all outputs low.
  - A packet truncated by reset is not resumed.

## Timing
- Grant latency: a queue becoming eligible in ARB is granted at the next rising edge. Its first beat can transfer in that XFER cycle.
- There is exactly one dead cycle (ARB) between consecutive packets, so peak throughput is B/(B+1) beats per cycle for B-beat packets.
- Data path has zero-cycle latency in XFER. AXIS rule: the slave's valid/data are held until ready; the arbiter adds no registering.
- Credit update is visible on credit_avail one cycle after the credit_updt edge, and is usable for eligibility in that same next cycle.

## Configuration
- Macro C2H_ARB_PKT_CNT_EN.
- When defined: per-queue 32-bit pkt_cnt increments on each accepted m_tlast beat of that queue. It wraps modulo 2^32 and resets to 0.
- When undefined: the pkt_cnt port and its counters are absent, and there is no other behavioural change.

## Structure
- Package c2h_arb_pkg holds:
  - the state enum typedef (ARB, XFER)
  - a credit saturating-add/subtract function
- Sub-module rr_pick: combinational round-robin priority picker with inputs req[NUM_Q] and last[QID_W], outputs any and idx[QID_W]. Instantiated once.

## Test plan
- Credit gating: reset; s_tvalid=4'b0001 with no credit → no grant for 20 cycles. Then credit_updt qid0 +4 with credit_perpkt=2 → grant one cycle later; credit_avail[0]=2 after grant.
- Round-robin fairness: all queues valid, 100 credits each, 3-beat packets, m_tready=1 → m_qid sequence 0,1,2,3,0…; each packet is 3 beats followed by 1 idle cycle.
- Backpressure: toggle m_tready 50% randomly mid-packet → beats from the granted queue are in order with no loss; no other queue's s_tready is ever asserted.
- Saturation and simultaneous update: credit[1]=0xFFFE, credit_updt +5 on the same cycle as a grant with perpkt=2 → credit[1]=0xFFFF. Separately, credit=3, +1 with grant −2 on the same cycle → 2.
- Enable and reset: deassert enable mid-packet → packet finishes and no further grants. Assert axi_aresetn low mid-packet → all outputs 0, credits 0; after release the first grant goes to queue 0.
- With C2H_ARB_PKT_CNT_EN defined: 7 packets from queue 2 → pkt_cnt[2]=7, other counters 0.

Source files
------------

// File: rtl/c2h_arb_pkg.sv
// Shared types and credit arithmetic for the C2H queue arbiter.
package c2h_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Add and/or subtract credits in wide arithmetic, saturating at 2^width-1.
    // The subtract never underflows: a grant requires cur >= sub.
    function automatic logic [63:0] credit_next(
        input logic [63:0] cur,
        input logic [63:0] add,
        input logic [63:0] sub,
        input logic        do_add,
        input logic        do_sub,
        input int unsigned width
    );
        logic [63:0] acc;
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        acc   = cur + (do_add ? add : 64'd0);
        acc   = acc - (do_sub ? sub : 64'd0);
        return (acc > max_v) ? max_v : acc;
    endfunction

endpackage

// File: rtl/c2h_queue_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last+1 with wrap.
module rr_pick #(
    parameter int NUM_Q = 4,
    parameter int QID_W = 2
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] last,
    output logic             any,
    output logic [QID_W-1:0] idx
);

    int               cand_s;
    logic [QID_W-1:0] cand_idx_s;

    // Scan from farthest to nearest candidate so the nearest requester wins.
    always_comb begin
        any        = |req;
        idx        = {QID_W{1'b0}};
        cand_s     = 0;
        cand_idx_s = {QID_W{1'b0}};
        for (int i = NUM_Q; i >= 1; i--) begin
            cand_s     = (int'(last) + i) % NUM_Q;
            cand_idx_s = cand_s[QID_W-1:0];
            idx        = req[cand_idx_s] ? cand_idx_s : idx;
        end
    end

endmodule

// File: rtl/c2h_queue_arbiter.sv
// Credit-gated, packet-granular round-robin arbiter for the shared C2H stream path.
// Optional per-queue packet counters are built when C2H_ARB_PKT_CNT_EN is defined.
module c2h_queue_arbiter
    import c2h_arb_pkg::*;
#(
    parameter int NUM_Q        = 4,
    parameter int QID_W        = 2,
    parameter int C_DATA_WIDTH = 512,
    parameter int TM_DSC_BITS  = 16
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              enable,
    input  logic                              credit_updt,
    input  logic [QID_W-1:0]                  credit_qid,
    input  logic [TM_DSC_BITS-1:0]            credit_in,
    input  logic [TM_DSC_BITS-1:0]            credit_perpkt,
    input  logic [NUM_Q*C_DATA_WIDTH-1:0]     s_tdata,
    input  logic [NUM_Q*C_DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [NUM_Q-1:0]                  s_tvalid,
    input  logic [NUM_Q-1:0]                  s_tlast,
    output logic [NUM_Q-1:0]                  s_tready,
    output logic [C_DATA_WIDTH-1:0]           m_tdata,
    output logic [C_DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [QID_W-1:0]                  m_qid,
    output logic [NUM_Q*TM_DSC_BITS-1:0]      credit_avail,
`ifdef C2H_ARB_PKT_CNT_EN
    output logic [NUM_Q*32-1:0]               pkt_cnt,
`endif
    output logic                              busy
);

    localparam int KEEP_W = C_DATA_WIDTH / 8;

    arb_state_e             state_r;
    logic [QID_W-1:0]       grant_r;
    logic [QID_W-1:0]       last_grant_r;
    logic [TM_DSC_BITS-1:0] credit_r      [NUM_Q];
    logic [TM_DSC_BITS-1:0] credit_nxt_s  [NUM_Q];
    logic [63:0]            credit_tmp_s;
    logic [NUM_Q-1:0]       elig_s;
    logic                   pick_any_s;
    logic [QID_W-1:0]       pick_s;
    logic                   grant_now_s;
    logic                   eop_s;

    // Eligibility: valid data and enough credit for one whole packet.
    always_comb begin
        elig_s = {NUM_Q{1'b0}};
        for (int i = 0; i < NUM_Q; i++) begin
            elig_s[i] = s_tvalid[i] && (credit_r[i] >= credit_perpkt);
        end
    end

    rr_pick #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_rr_pick (
        .req  (elig_s),
        .last (last_grant_r),
        .any  (pick_any_s),
        .idx  (pick_s)
    );

    assign grant_now_s = (state_r == ARB) && enable && pick_any_s;
    assign eop_s       = (state_r == XFER) && m_tvalid && m_tready && m_tlast;

    // Grant FSM: one packet per grant, one ARB cycle between packets.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r      <= ARB;
            grant_r      <= {QID_W{1'b0}};
            last_grant_r <= QID_W'(NUM_Q - 1);
        end else begin
            case (state_r)
                ARB: begin
                    if (grant_now_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        state_r      <= XFER;
                    end else begin
                        state_r      <= ARB;
                    end
                end
                XFER: begin
                    if (eop_s) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= XFER;
                    end
                end
                default: state_r <= ARB;
            endcase
        end
    end

    // Next credit per queue: return and grant on the same queue combine before saturating.
    always_comb begin
        credit_tmp_s = 64'd0;
        for (int i = 0; i < NUM_Q; i++) begin
            credit_tmp_s = credit_next(
                {{(64-TM_DSC_BITS){1'b0}}, credit_r[i]},
                {{(64-TM_DSC_BITS){1'b0}}, credit_in},
                {{(64-TM_DSC_BITS){1'b0}}, credit_perpkt},
                credit_updt && (credit_qid == QID_W'(i)),
                grant_now_s && (pick_s == QID_W'(i)),
                TM_DSC_BITS);
            credit_nxt_s[i] = credit_tmp_s[TM_DSC_BITS-1:0];
        end
    end

    // Credit registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_Q; i++) begin
                credit_r[i] <= {TM_DSC_BITS{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                credit_r[i] <= credit_nxt_s[i];
            end
        end
    end

    // Flatten credit registers onto the status port.
    always_comb begin
        credit_avail = {(NUM_Q*TM_DSC_BITS){1'b0}};
        for (int i = 0; i < NUM_Q; i++) begin
            credit_avail[i*TM_DSC_BITS +: TM_DSC_BITS] = credit_r[i];
        end
    end

    // Zero-latency pass-through of the granted queue; everything idle outside XFER.
    always_comb begin
        m_tdata  = {C_DATA_WIDTH{1'b0}};
        m_tkeep  = {KEEP_W{1'b0}};
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_qid    = {QID_W{1'b0}};
        s_tready = {NUM_Q{1'b0}};
        busy     = 1'b0;
        if (state_r == XFER) begin
            m_tdata           = s_tdata[int'(grant_r)*C_DATA_WIDTH +: C_DATA_WIDTH];
            m_tkeep           = s_tkeep[int'(grant_r)*KEEP_W +: KEEP_W];
            m_tvalid          = s_tvalid[grant_r];
            m_tlast           = s_tlast[grant_r];
            s_tready[grant_r] = m_tready;
            m_qid             = grant_r;
            busy              = 1'b1;
        end else begin
            busy              = 1'b0;
        end
    end

`ifdef C2H_ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt_r [NUM_Q];

    // Count accepted end-of-packet beats per queue, wrapping modulo 2^32.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_Q; i++) begin
                pkt_cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (eop_s && (grant_r == QID_W'(i))) begin
                    pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the status port.
    always_comb begin
        pkt_cnt = {(NUM_Q*32){1'b0}};
        for (int i = 0; i < NUM_Q; i++) begin
            pkt_cnt[i*32 +: 32] = pkt_cnt_r[i];
        end
    end
`else
    // Packet counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_c2h_queue_arbiter.sv
// Directed self-checking bench for c2h_queue_arbiter (4 queues, 32-bit data, 16-bit credits).
module tb_c2h_queue_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         credit_updt;
    logic [1:0]   credit_qid;
    logic [15:0]  credit_in;
    logic [15:0]  credit_perpkt;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    logic [3:0]   s_tready;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [1:0]   m_qid;
    logic [63:0]  credit_avail;
    logic         busy;
`ifdef C2H_ARB_PKT_CNT_EN
    logic [127:0] pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Source model: per-queue packet length, packets to send, progress.
    int src_len [4];
    int src_n   [4];
    int src_pkt [4];
    int src_beat[4];

    logic [1:0]  log_q[$];
    logic [31:0] log_d[$];
    logic        log_l[$];
    logic [3:0]  log_k[$];
    logic        busy_log[$];
    int          tready_viol;

    always #5 clk = ~clk;

    c2h_queue_arbiter #(
        .NUM_Q        (4),
        .QID_W        (2),
        .C_DATA_WIDTH (32),
        .TM_DSC_BITS  (16)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .enable        (enable),
        .credit_updt   (credit_updt),
        .credit_qid    (credit_qid),
        .credit_in     (credit_in),
        .credit_perpkt (credit_perpkt),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .m_qid         (m_qid),
        .credit_avail  (credit_avail),
`ifdef C2H_ARB_PKT_CNT_EN
        .pkt_cnt       (pkt_cnt),
`endif
        .busy          (busy)
    );

    function automatic logic [31:0] exp_data(input int q, input int p, input int b);
        return {q[7:0], p[7:0], b[7:0], 8'h5A};
    endfunction

    task automatic drive_src();
        for (int q = 0; q < 4; q++) begin
            if (src_pkt[q] < src_n[q]) begin
                s_tvalid[q]        = 1'b1;
                s_tlast[q]         = (src_beat[q] == src_len[q] - 1);
                s_tdata[q*32 +: 32] = exp_data(q, src_pkt[q], src_beat[q]);
                s_tkeep[q*4 +: 4]  = s_tlast[q] ? 4'h7 : 4'hF;
            end else begin
                s_tvalid[q]        = 1'b0;
                s_tlast[q]         = 1'b0;
                s_tdata[q*32 +: 32] = 32'd0;
                s_tkeep[q*4 +: 4]  = 4'h0;
            end
        end
    endtask

    task automatic set_src(input int q, input int len, input int n);
        src_len[q]  = len;
        src_n[q]    = n;
        src_pkt[q]  = 0;
        src_beat[q] = 0;
    endtask

    task automatic clear_src();
        for (int q = 0; q < 4; q++) set_src(q, 1, 0);
        drive_src();
    endtask

    task automatic clear_logs();
        log_q.delete();
        log_d.delete();
        log_l.delete();
        log_k.delete();
        busy_log.delete();
        tready_viol = 0;
    endtask

    function automatic bit all_done();
        for (int q = 0; q < 4; q++) if (src_pkt[q] < src_n[q]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: sample handshakes before the edge, advance sources after it.
    task automatic tick();
        logic [3:0] fired;
        #1;
        fired = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            log_q.push_back(m_qid);
            log_d.push_back(m_tdata);
            log_l.push_back(m_tlast);
            log_k.push_back(m_tkeep);
        end
        busy_log.push_back(busy);
        if (((s_tready & ~(4'b0001 << m_qid)) != 4'b0000) || (!busy && s_tready != 4'b0000))
            tready_viol++;
        @(posedge clk);
        #1;
        for (int q = 0; q < 4; q++) begin
            if (fired[q]) begin
                if (src_beat[q] == src_len[q] - 1) begin
                    src_beat[q] = 0;
                    src_pkt[q]++;
                end else begin
                    src_beat[q]++;
                end
            end
        end
        drive_src();
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        credit_updt   = 1'b0;
        credit_qid    = 2'd0;
        credit_in     = 16'd0;
        credit_perpkt = 16'd0;
        m_tready      = 1'b0;
        clear_src();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        clear_logs();
    endtask

    task automatic load_credit(input logic [1:0] q, input logic [15:0] amt);
        credit_updt = 1'b1;
        credit_qid  = q;
        credit_in   = amt;
        tick();
        credit_updt = 1'b0;
        credit_in   = 16'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b tvalid=%b tlast=%b want 0 0 0", busy, m_tvalid, m_tlast);
        end
        checks++;
        if (s_tready !== 4'h0 || m_qid !== 2'd0 || m_tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got tready=%h qid=%0d tdata=%h want 0 0 0", s_tready, m_qid, m_tdata);
        end
        checks++;
        if (credit_avail !== 64'd0) begin
            errors++;
            $display("FAIL reset_credit got %h want 0", credit_avail);
        end
    endtask

    task automatic test_credit_gating();
        int grants;
        apply_reset();
        enable = 1'b1;
        m_tready = 1'b1;
        credit_perpkt = 16'd2;
        set_src(0, 2, 1);
        drive_src();
        repeat (20) tick();
        grants = 0;
        foreach (busy_log[k]) if (busy_log[k]) grants++;
        checks++;
        if (grants != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_no_credit got busy_cycles=%0d want 0", grants);
        end
        load_credit(2'd0, 16'd4);
        checks++;
        if (busy !== 1'b0 || credit_avail[15:0] !== 16'd4) begin
            errors++;
            $display("FAIL gate_credit_visible got busy=%b credit=%0d want 0 4", busy, credit_avail[15:0]);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || m_qid !== 2'd0 || credit_avail[15:0] !== 16'd2) begin
            errors++;
            $display("FAIL gate_grant got busy=%b qid=%0d credit=%0d want 1 0 2", busy, m_qid, credit_avail[15:0]);
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== exp_data(0, 0, 0)) begin
            errors++;
            $display("FAIL gate_first_beat got valid=%b data=%h want 1 %h", m_tvalid, m_tdata, exp_data(0, 0, 0));
        end
        for (int i = 0; i < 20 && (!all_done() || busy); i++) tick();
        checks++;
        if (log_d.size() != 2 || !all_done() || busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_pkt_done got beats=%0d busy=%b want 2 0", log_d.size(), busy);
        end else begin
            checks++;
            if (log_d[1] !== exp_data(0, 0, 1) || log_l[1] !== 1'b1 || log_k[1] !== 4'h7) begin
                errors++;
                $display("FAIL gate_last_beat got %h last=%b keep=%h want %h 1 7", log_d[1], log_l[1], log_k[1], exp_data(0, 0, 1));
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        enable = 1'b1;
        m_tready = 1'b1;
        credit_perpkt = 16'd1;
        for (int q = 0; q < 4; q++) load_credit(q[1:0], 16'd100);
        for (int q = 0; q < 4; q++) set_src(q, 3, 2);
        drive_src();
        clear_logs();
        repeat (32) tick();
        checks++;
        if (log_d.size() != 24) begin
            errors++;
            $display("FAIL rr_beat_count got %0d want 24", log_d.size());
        end else begin
            for (int j = 0; j < 24; j++) begin
                checks++;
                if (log_q[j] !== 2'((j / 3) % 4) || log_d[j] !== exp_data((j / 3) % 4, j / 12, j % 3)
                    || log_l[j] !== (j % 3 == 2)) begin
                    errors++;
                    $display("FAIL rr_beat%0d got qid=%0d data=%h last=%b want qid=%0d data=%h", j,
                             log_q[j], log_d[j], log_l[j], (j / 3) % 4, exp_data((j / 3) % 4, j / 12, j % 3));
                end
            end
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (busy_log[k] !== (k % 4 != 0)) begin
                errors++;
                $display("FAIL rr_busy_cycle%0d got %b want %b", k, busy_log[k], (k % 4 != 0));
            end
        end
        checks++;
        if (credit_avail !== {4{16'd98}}) begin
            errors++;
            $display("FAIL rr_credit got %h want %h", credit_avail, {4{16'd98}});
        end
    endtask

    task automatic test_backpressure();
        int ep[4];
        int eb[4];
        apply_reset();
        enable = 1'b1;
        m_tready = 1'b1;
        credit_perpkt = 16'd1;
        for (int q = 0; q < 4; q++) load_credit(q[1:0], 16'd20);
        set_src(0, 4, 2);
        set_src(1, 3, 2);
        set_src(2, 5, 1);
        set_src(3, 2, 3);
        drive_src();
        clear_logs();
        for (int i = 0; i < 400 && (!all_done() || busy); i++) begin
            m_tready = 1'($urandom_range(0, 1));
            tick();
        end
        m_tready = 1'b1;
        checks++;
        if (!all_done() || busy !== 1'b0 || log_d.size() != 25) begin
            errors++;
            $display("FAIL bp_complete got beats=%0d busy=%b want 25 0", log_d.size(), busy);
        end
        for (int q = 0; q < 4; q++) begin
            ep[q] = 0;
            eb[q] = 0;
        end
        foreach (log_d[j]) begin
            int q;
            q = int'(log_q[j]);
            checks++;
            if (log_d[j] !== exp_data(q, ep[q], eb[q]) || (j > 0 && !log_l[j-1] && log_q[j] !== log_q[j-1])) begin
                errors++;
                $display("FAIL bp_beat%0d got qid=%0d data=%h want data=%h", j, log_q[j], log_d[j], exp_data(q, ep[q], eb[q]));
            end
            if (eb[q] == src_len[q] - 1) begin
                eb[q] = 0;
                ep[q]++;
            end else begin
                eb[q]++;
            end
        end
        checks++;
        if (tready_viol != 0) begin
            errors++;
            $display("FAIL bp_tready_exclusive got violations=%0d want 0", tready_viol);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        enable = 1'b1;
        m_tready = 1'b0;
        credit_perpkt = 16'd2;
        load_credit(2'd1, 16'hFFFE);
        checks++;
        if (credit_avail[31:16] !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload got %h want fffe", credit_avail[31:16]);
        end
        set_src(1, 1, 1);
        drive_src();
        load_credit(2'd1, 16'd5);
        checks++;
        if (busy !== 1'b1 || m_qid !== 2'd1 || credit_avail[31:16] !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_update_grant got busy=%b qid=%0d credit=%h want 1 1 ffff", busy, m_qid, credit_avail[31:16]);
        end
        m_tready = 1'b1;
        tick();
        load_credit(2'd3, 16'd3);
        set_src(3, 1, 1);
        drive_src();
        load_credit(2'd3, 16'd1);
        checks++;
        if (busy !== 1'b1 || m_qid !== 2'd3 || credit_avail[63:48] !== 16'd2) begin
            errors++;
            $display("FAIL simul_update_grant got busy=%b qid=%0d credit=%0d want 1 3 2", busy, m_qid, credit_avail[63:48]);
        end
        tick();
        credit_perpkt = 16'd0;
        set_src(2, 1, 1);
        drive_src();
        tick();
        checks++;
        if (busy !== 1'b1 || m_qid !== 2'd2 || credit_avail[47:32] !== 16'd0) begin
            errors++;
            $display("FAIL zero_perpkt got busy=%b qid=%0d credit=%0d want 1 2 0", busy, m_qid, credit_avail[47:32]);
        end
        tick();
    endtask

    task automatic test_enable_reset();
        apply_reset();
        enable = 1'b1;
        m_tready = 1'b1;
        credit_perpkt = 16'd1;
        load_credit(2'd0, 16'd10);
        load_credit(2'd1, 16'd10);
        set_src(0, 4, 1);
        set_src(1, 4, 1);
        drive_src();
        clear_logs();
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        repeat (5) tick();
        checks++;
        if (log_d.size() != 4 || busy !== 1'b0 || credit_avail[31:16] !== 16'd10) begin
            errors++;
            $display("FAIL enable_off got beats=%0d busy=%b credit1=%0d want 4 0 10", log_d.size(), busy, credit_avail[31:16]);
        end else begin
            checks++;
            if (log_q[3] !== 2'd0 || log_l[3] !== 1'b1 || log_d[3] !== exp_data(0, 0, 3)) begin
                errors++;
                $display("FAIL enable_pkt_tail got qid=%0d data=%h want 0 %h", log_q[3], log_d[3], exp_data(0, 0, 3));
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || m_qid !== 2'd1) begin
            errors++;
            $display("FAIL enable_regrant got busy=%b qid=%0d want 1 1", busy, m_qid);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || s_tready !== 4'h0
            || m_qid !== 2'd0 || m_tdata !== 32'd0 || m_tkeep !== 4'h0 || credit_avail !== 64'd0) begin
            errors++;
            $display("FAIL midpkt_reset got busy=%b valid=%b tready=%h qid=%0d credit=%h want all 0",
                     busy, m_tvalid, s_tready, m_qid, credit_avail);
        end
        clear_src();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        load_credit(2'd0, 16'd5);
        load_credit(2'd2, 16'd5);
        set_src(0, 1, 1);
        set_src(2, 1, 1);
        drive_src();
        tick();
        checks++;
        if (busy !== 1'b1 || m_qid !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_first got busy=%b qid=%0d want 1 0", busy, m_qid);
        end
        repeat (4) tick();
    endtask

`ifdef C2H_ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        apply_reset();
        enable = 1'b1;
        m_tready = 1'b1;
        credit_perpkt = 16'd1;
        load_credit(2'd2, 16'd100);
        set_src(2, 2, 7);
        drive_src();
        for (int i = 0; i < 100 && (!all_done() || busy); i++) tick();
        checks++;
        if (pkt_cnt[95:64] !== 32'd7 || pkt_cnt[63:0] !== 64'd0 || pkt_cnt[127:96] !== 32'd0) begin
            errors++;
            $display("FAIL pkt_cnt got %h want q2=7 others 0", pkt_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_credit_gating();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_enable_reset();
`ifdef C2H_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
